// File: rtl/pass_keeper_pkg.sv
// Shared constants and mirror FSM state for the password-keeper flash storage stage.
package pass_keeper_pkg;
  localparam int ENTRY_W         = 256;
  localparam int DEPTH           = 16;
  localparam int ADDR_W          = 4;
  localparam int BYTES_PER_ENTRY = 32;
  localparam int CNT_W           = 5;
  localparam int NVM_AW          = 9;

  typedef enum logic {IDLE, SEND} mirror_state_e;
endpackage

// File: rtl/nvm_byte_serializer.sv
// Latches one record and streams it LSB byte first to the NVM over a req/ack handshake.
module nvm_byte_serializer
  import pass_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  idx,
  input  logic [ENTRY_W-1:0] rec,
  input  logic               nvm_ack,
  output logic               busy,
  output logic               nvm_req,
  output logic [NVM_AW-1:0]  nvm_addr,
  output logic [7:0]         nvm_wdata
);
  mirror_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ENTRY_W-1:0] rec_q, rec_d;

  // rec_q is shifted down on every ack so the current byte always sits in [7:0].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SEND;
        cnt_d   = '0;
        idx_d   = idx;
        rec_d   = rec;
      end
      SEND: if (nvm_ack) begin
        if (cnt_q == CNT_W'(BYTES_PER_ENTRY - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          rec_d = rec_q >> 8;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
    end
  end

  assign busy      = (state_q == SEND);
  assign nvm_req   = (state_q == SEND);
  assign nvm_addr  = {idx_q, cnt_q};
  assign nvm_wdata = rec_q[7:0];
endmodule

// File: rtl/flash_store_ctrl.sv
// Shadow record store with write-first read port, max-address tracking and NVM mirroring.
// Define STORE_CLEAR_EN to add the `clear` input that wipes the array while idle.
module flash_store_ctrl
  import pass_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flash_write,
  input  logic [ADDR_W-1:0]  add_flash,
  input  logic [ENTRY_W-1:0] write_data_flash,
`ifdef STORE_CLEAR_EN
  input  logic               clear,
`endif
  output logic [ENTRY_W-1:0] data_flash,
  output logic [ADDR_W-1:0]  max_address,
  output logic               busy,
  output logic               wr_overrun,
  output logic               nvm_req,
  output logic [NVM_AW-1:0]  nvm_addr,
  output logic [7:0]         nvm_wdata,
  input  logic               nvm_ack
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [ENTRY_W-1:0] data_flash_q, data_flash_d;
  logic [ADDR_W-1:0]  max_address_q, max_address_d;
  logic               wr_overrun_q, wr_overrun_d;
  logic               clr_acc, wr_acc;

`ifdef STORE_CLEAR_EN
  assign clr_acc = clear & ~busy;
`else
  assign clr_acc = 1'b0;
`endif
  // clear has priority over a same-cycle write; such a write is silently dropped.
  assign wr_acc = flash_write & ~busy & ~clr_acc;

  always_comb begin
    mem_d         = mem_q;
    max_address_d = max_address_q;
    wr_overrun_d  = wr_overrun_q | (flash_write & busy);
    data_flash_d  = mem_q[add_flash];
    if (clr_acc) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      max_address_d = '0;
      data_flash_d  = '0;
    end else if (wr_acc) begin
      mem_d[add_flash] = write_data_flash;
      data_flash_d     = write_data_flash;
      if (add_flash > max_address_q) max_address_d = add_flash;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_flash_q  <= '0;
      max_address_q <= '0;
      wr_overrun_q  <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      data_flash_q  <= data_flash_d;
      max_address_q <= max_address_d;
      wr_overrun_q  <= wr_overrun_d;
    end
  end

  nvm_byte_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .start    (wr_acc),
    .idx      (add_flash),
    .rec      (write_data_flash),
    .nvm_ack  (nvm_ack),
    .busy     (busy),
    .nvm_req  (nvm_req),
    .nvm_addr (nvm_addr),
    .nvm_wdata(nvm_wdata)
  );

  assign data_flash  = data_flash_q;
  assign max_address = max_address_q;
  assign wr_overrun  = wr_overrun_q;
endmodule

// File: tb/tb_flash_store_ctrl.sv
// Scoreboard bench for flash_store_ctrl: expected NVM bytes queued at write time, popped on ack.
module tb_flash_store_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         flash_write;
  logic [3:0]   add_flash;
  logic [255:0] write_data_flash;
  logic         clear;
  logic [255:0] data_flash;
  logic [3:0]   max_address;
  logic         busy, wr_overrun, nvm_req, nvm_ack;
  logic [8:0]   nvm_addr;
  logic [7:0]   nvm_wdata;

  int n_chk = 0, n_pass = 0;
  int stall = 0, wait_cnt = 0, bytes_acc = 0;
  logic [16:0]  sb [$];
  logic [255:0] ref_mem [16];
  logic [3:0]   ref_max;
  logic         pend = 1'b0;
  logic [8:0]   prev_addr;
  logic [7:0]   prev_data;

  always #5 clk = ~clk;

  flash_store_ctrl dut (
    .clk(clk), .rst(rst), .flash_write(flash_write), .add_flash(add_flash),
    .write_data_flash(write_data_flash),
`ifdef STORE_CLEAR_EN
    .clear(clear),
`endif
    .data_flash(data_flash), .max_address(max_address), .busy(busy),
    .wr_overrun(wr_overrun), .nvm_req(nvm_req), .nvm_addr(nvm_addr),
    .nvm_wdata(nvm_wdata), .nvm_ack(nvm_ack)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
    else n_pass++;
  endtask

  // NVM model: ack after `stall` low cycles per byte.
  initial begin
    nvm_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!nvm_req) begin nvm_ack = 1'b0; wait_cnt = 0; end
      else if (wait_cnt < stall) begin nvm_ack = 1'b0; wait_cnt++; end
      else begin nvm_ack = 1'b1; wait_cnt = 0; end
    end
  end

  always @(negedge clk) begin
    if (!rst) pend = 1'b0;
    else if (nvm_req) begin
      if (pend) begin
        chk("stall_addr", 256'(nvm_addr), 256'(prev_addr));
        chk("stall_data", 256'(nvm_wdata), 256'(prev_data));
      end
      if (nvm_ack) begin
        if (sb.size() == 0) chk("sb_spurious", 1, 0);
        else chk("nvm_byte", 256'({nvm_addr, nvm_wdata}), 256'(sb.pop_front()));
        bytes_acc++;
        pend = 1'b0;
      end else pend = 1'b1;
      prev_addr = nvm_addr;
      prev_data = nvm_wdata;
    end else pend = 1'b0;
  end

  task automatic wr(input logic [3:0] a, input logic [255:0] d, input bit exp_acc);
    @(posedge clk); #1;
    flash_write = 1'b1; add_flash = a; write_data_flash = d;
    if (exp_acc) begin
      ref_mem[a] = d;
      if (a > ref_max) ref_max = a;
      for (int b = 0; b < 32; b++) sb.push_back({a, 5'(b), d[8*b +: 8]});
    end
    @(posedge clk); #1;
    flash_write = 1'b0;
    chk("rd_after_wr", data_flash, ref_mem[a]);
    chk("max_addr", 256'(max_address), 256'(ref_max));
    if (exp_acc) chk("busy_set", 256'(busy), 1);
    else chk("overrun_set", 256'(wr_overrun), 1);
  endtask

  task automatic rd(input logic [3:0] a);
    @(posedge clk); #1; add_flash = a;
    @(posedge clk); #1;
    chk("rd", data_flash, ref_mem[a]);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) break;
    end
    chk("idle_busy", 256'(busy), 0);
    chk("idle_sb_drained", 256'(sb.size()), 0);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] a_dat;
    bit hit;
    rst = 1'b0; flash_write = 1'b0; add_flash = '0; write_data_flash = '0; clear = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_max = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_flash, 0);
    chk("rst_max", 256'(max_address), 0);
    chk("rst_busy", 256'(busy), 0);
    chk("rst_ovr", 256'(wr_overrun), 0);
    chk("rst_req", 256'(nvm_req), 0);
    chk("rst_addr", 256'(nvm_addr), 0);
    chk("rst_wdata", 256'(nvm_wdata), 0);
    rst = 1'b1;

    // Basic write at 3, ack held high.
    a_dat = rnd256();
    wr(4'd3, a_dat, 1'b1);
    wait_idle();
    rd(4'd3);

    // max tracking, plus a write on the first idle cycle after busy falls.
    wr(4'd7, rnd256(), 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    wr(4'd2, rnd256(), 1'b1);
    wait_idle();
    wr(4'd15, rnd256(), 1'b1);
    wait_idle();

    // Overrun: second write while busy is dropped.
    wr(4'd4, rnd256(), 1'b1);
    wr(4'd9, rnd256(), 1'b0);
    wait_idle();
    chk("ovr_sticky", 256'(wr_overrun), 1);
    rd(4'd9);
    rd(4'd4);

    // Ack stalls of 5 cycles per byte.
    stall = 5;
    wr(4'd6, rnd256(), 1'b1);
    wait_idle();
    stall = 0;

    // Reset at byte 10 of a transfer.
    bytes_acc = 0;
    wr(4'd8, rnd256(), 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bytes_acc >= 10) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("reach_byte10", 256'(hit), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_req", 256'(nvm_req), 0);
    chk("mid_rst_busy", 256'(busy), 0);
    chk("mid_rst_max", 256'(max_address), 0);
    chk("mid_rst_data", data_flash, 0);
    chk("mid_rst_ovr", 256'(wr_overrun), 0);
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_max = '0;
    rd(4'd3);
    wr(4'd5, rnd256(), 1'b1);
    wait_idle();

`ifdef STORE_CLEAR_EN
    for (int i = 0; i < 5; i++) begin
      wr(4'(i), rnd256(), 1'b1);
      wait_idle();
    end
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_max = '0;
    chk("clr_max", 256'(max_address), 0);
    for (int i = 0; i < 6; i++) rd(4'(i));
    // Clear during a transfer is ignored.
    wr(4'd1, rnd256(), 1'b1);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    wait_idle();
    rd(4'd1);
    chk("clr_busy_max", 256'(max_address), 1);
    // Clear beats a same-cycle write.
    @(posedge clk); #1; clear = 1'b1; flash_write = 1'b1; add_flash = 4'd2;
    write_data_flash = rnd256();
    @(posedge clk); #1; clear = 1'b0; flash_write = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_max = '0;
    chk("clr_wr_busy", 256'(busy), 0);
    chk("clr_wr_ovr", 256'(wr_overrun), 0);
    rd(4'd2);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
